mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-ported chip RAM of the single-cycle computer.
- Shares one RAM between the instruction-fetch port (IF, read-only) and the load/store port (LS, read/write).
- Drives the RAM's CS/WE/OE/address/data_in pins and returns read data with a valid pulse.
- Round-robin arbitration; one RAM access in flight at a time.

Parameters:
ADDR_W, 32, RAM address width.
DATA_W, 32, RAM data width.
RD_LAT, 1, cycles from the RAM read-issue cycle to a valid mem_dout; legal range 1..7.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
if_req  input  1  fetch request; held with if_addr until if_gnt.
if_addr  input  ADDR_W  fetch address.
if_gnt  output  1  one-cycle pulse in the cycle IF's access is issued.
if_rvalid  output  1  one-cycle pulse; if_rdata valid.
if_rdata  output  DATA_W  fetch data; held until the next IF read completes.
ls_req  input  1  load/store request; held with ls_we, ls_addr and ls_wdata until ls_gnt.
ls_we  input  1  1 = write, 0 = read.
ls_addr  input  ADDR_W  load/store address.
ls_wdata  input  DATA_W  store data.
ls_gnt  output  1  one-cycle pulse in the cycle LS's access is issued.
ls_rvalid  output  1  one-cycle pulse on LS read completion; never raised for writes.
ls_rdata  output  DATA_W  load data; held until the next LS read completes.
mem_cs, mem_we, mem_oe  output  1 each  RAM chip-select, write-enable, output-enable.
mem_addr  output  ADDR_W  RAM address.
mem_din  output  DATA_W  RAM write data.
mem_dout  input  DATA_W  RAM read data.

Behaviour:
- Reset values (async on rst_n low): every output 0, state IDLE, latency counter 0, round-robin pointer = LS-preferred.
- FSM states:
  - IDLE: if no request, stay in IDLE. If any request, pick the winner and latch its op, address and data into registers. Go to ISSUE.
  - ISSUE (exactly 1 cycle): mem_cs=1 and mem_addr = latched address. Winner's gnt pulses this cycle.
    - Write: mem_we=1, mem_oe=0, mem_din = latched data; next state IDLE.
    - Read: mem_we=0, mem_oe=1; next state WAIT, counter = RD_LAT-1.
  - WAIT: mem_cs=1, mem_oe=1, mem_addr held, mem_we=0. Decrement the counter each cycle; when it is 0, sample mem_dout at the edge ending that cycle and go to DONE. With RD_LAT=1, WAIT lasts 1 cycle.
  - DONE (1 cycle): the owner's rvalid=1, rdata = sampled value, mem_cs=mem_oe=0; next state IDLE.
- Outside ISSUE/WAIT: mem_cs, mem_we and mem_oe are 0; mem_addr and mem_din hold their last values.
- Arbitration:
  - Evaluated only in IDLE.
  - Single requester wins.
  - If both request, the pointer decides. The pointer flips to the other requester after each grant, so the first contention after reset goes to LS, the next to IF.
- Latency from req (sampled in IDLE):
  - gnt comes 1 cycle later.
  - Write: 2 cycles per access (IDLE, ISSUE).
  - Read: rvalid comes RD_LAT+2 cycles after the request is sampled.
- IF is read-only: ls_we has no effect on IF accesses.
- A request deasserted before its grant is legal. It is ignored if it is low in IDLE; there is no queuing.
- Request inputs are don't-care while not in IDLE. Once latched, the access completes even if req drops.
- mem_we and mem_oe are never 1 in the same cycle.
- rst_n asserted mid-access: the access is aborted immediately, no rvalid is raised, rdata is cleared, and the FSM resumes in IDLE after rst_n deasserts.

Test Plan:
- Reset: rst_n=0 mid-WAIT of an LS read -> all outputs 0 immediately; after release, no ls_rvalid ever appears for the aborted read.
- IF-only read, RD_LAT=1, if_addr=0x10, RAM returns 0xDEADBEEF -> if_gnt at T+1 with mem_cs=1, mem_oe=1, mem_addr=0x10; if_rvalid=1 and if_rdata=0xDEADBEEF at T+3.
- LS write, ls_addr=0x24, ls_wdata=0x12345678 -> at T+1: ls_gnt=1, mem_cs=1, mem_we=1, mem_oe=0, mem_din=0x12345678; FSM back in IDLE at T+2; ls_rvalid never raised.
- Contention: both requesters held high continuously from reset -> grants alternate LS, IF, LS, IF; neither port is granted twice in a row.
- RD_LAT=3 LS read -> mem_cs and mem_oe high for 4 cycles (ISSUE plus 3 WAIT); ls_rvalid at T+5; ls_rdata holds the value after the pulse.
- Withdrawn request: if_req high for one cycle during an LS WAIT, then low -> no if_gnt is issued and the FSM stays in IDLE after DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter and access sequencer sharing one
//               single-ported RAM between instruction fetch and load/store.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ISSUE = 2'd1;
    localparam logic [1:0] C_WAIT  = 2'd2;
    localparam logic [1:0] C_DONE  = 2'd3;

    localparam logic [2:0] C_LAT_M1 = 3'(RD_LAT - 1);

    logic [1:0]        state_q,    state_d;
    logic              owner_ls_q, owner_ls_d;
    logic              ptr_ls_q,   ptr_ls_d;
    logic              we_q,       we_d;
    logic [2:0]        cnt_q,      cnt_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] din_q,      din_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              w_pick_ls;

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        ptr_ls_d   = ptr_ls_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        // LS wins when it is the only requester or when the pointer favours it.
        w_pick_ls  = ls_req && (!if_req || ptr_ls_q);

        case (state_q)
            C_IDLE: begin
                if (if_req || ls_req) begin
                    owner_ls_d = w_pick_ls;
                    ptr_ls_d   = !w_pick_ls;
                    we_d       = w_pick_ls && ls_we;
                    addr_d     = w_pick_ls ? ls_addr : if_addr;
                    if (w_pick_ls && ls_we) begin
                        din_d = ls_wdata;
                    end
                    state_d    = C_ISSUE;
                end
            end
            C_ISSUE: begin
                if (we_q) begin
                    state_d = C_IDLE;
                end else begin
                    state_d = C_WAIT;
                    cnt_d   = C_LAT_M1;
                end
            end
            C_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = C_DONE;
                    if (owner_ls_q) begin
                        ls_rdata_d = mem_dout;
                    end else begin
                        if_rdata_d = mem_dout;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= C_IDLE;
            owner_ls_q <= 1'b0;
            ptr_ls_q   <= 1'b1;
            we_q       <= 1'b0;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            din_q      <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            ptr_ls_q   <= ptr_ls_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // All outputs decode from registered state, so reset clears them at once.
    assign if_gnt    = (state_q == C_ISSUE) && !owner_ls_q;
    assign ls_gnt    = (state_q == C_ISSUE) &&  owner_ls_q;
    assign if_rvalid = (state_q == C_DONE)  && !owner_ls_q;
    assign ls_rvalid = (state_q == C_DONE)  &&  owner_ls_q;
    assign mem_cs    = (state_q == C_ISSUE) || (state_q == C_WAIT);
    assign mem_we    = (state_q == C_ISSUE) &&  we_q;
    assign mem_oe    = ((state_q == C_ISSUE) && !we_q) || (state_q == C_WAIT);
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Randomised bench for mem_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_dout = '0;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_cs, mem_we, mem_oe;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_din;

    logic        if_req_1 = 1'b0, ls_req_1 = 1'b0, ls_we_1 = 1'b0;
    logic [31:0] if_addr_1 = '0, ls_addr_1 = '0, ls_wdata_1 = '0, mem_dout_1 = '0;
    logic        if_gnt_1, if_rvalid_1, ls_gnt_1, ls_rvalid_1, mem_cs_1, mem_we_1, mem_oe_1;
    logic [31:0] if_rdata_1, ls_rdata_1, mem_addr_1, mem_din_1;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_gnt(if_gnt_1),
        .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .ls_req(ls_req_1), .ls_we(ls_we_1), .ls_addr(ls_addr_1), .ls_wdata(ls_wdata_1),
        .ls_gnt(ls_gnt_1), .ls_rvalid(ls_rvalid_1), .ls_rdata(ls_rdata_1),
        .mem_cs(mem_cs_1), .mem_we(mem_we_1), .mem_oe(mem_oe_1),
        .mem_addr(mem_addr_1), .mem_din(mem_din_1), .mem_dout(mem_dout_1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] ram [logic [31:0]];
    int          cyc = 0;
    int          g = 0;          // cycle in which the active access is issued
    bit          active = 0, t_ls = 0, t_we = 0, ptr_ls = 1;
    logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
    logic [31:0] m_addr = '0, m_din = '0, m_if_rdata = '0, m_ls_rdata = '0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    initial begin
        bit e_gnt, e_cs, e_rv, pick_ls;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0; ptr_ls = 1;
                m_addr = '0; m_din = '0; m_if_rdata = '0; m_ls_rdata = '0;
            end else begin
                cyc++;
                if (active && cyc == g) begin
                    m_addr = t_addr;
                    if (t_we) begin
                        m_din = t_wdata;
                        ram[t_addr] = t_wdata;
                    end
                end
                if (active && !t_we && cyc == g + LAT + 1) begin
                    if (t_ls) m_ls_rdata = t_rdata;
                    else      m_if_rdata = t_rdata;
                end
                e_gnt = active && cyc == g;
                e_cs  = active && cyc >= g && cyc <= g + (t_we ? 0 : LAT);
                e_rv  = active && !t_we && cyc == g + LAT + 1;
                chk("if_gnt",    if_gnt,    e_gnt && !t_ls);
                chk("ls_gnt",    ls_gnt,    e_gnt &&  t_ls);
                chk("mem_cs",    mem_cs,    e_cs);
                chk("mem_we",    mem_we,    e_gnt && t_we);
                chk("mem_oe",    mem_oe,    e_cs && !t_we);
                chk("if_rvalid", if_rvalid, e_rv && !t_ls);
                chk("ls_rvalid", ls_rvalid, e_rv &&  t_ls);
                chk("mem_addr",  mem_addr,  m_addr);
                chk("mem_din",   mem_din,   m_din);
                chk("if_rdata",  if_rdata,  m_if_rdata);
                chk("ls_rdata",  ls_rdata,  m_ls_rdata);
                if (active && cyc >= g + (t_we ? 1 : LAT + 2)) active = 0;
                // RAM data is only correct in the last wait cycle; otherwise noise.
                mem_dout = (active && !t_we && cyc == g + LAT) ? t_rdata : $urandom;
                if (!active && (if_req || ls_req)) begin
                    pick_ls = ls_req && (!if_req || ptr_ls);
                    ptr_ls  = !pick_ls;
                    active  = 1;
                    g       = cyc + 1;
                    t_ls    = pick_ls;
                    t_we    = pick_ls && ls_we;
                    t_addr  = pick_ls ? ls_addr : if_addr;
                    t_wdata = ls_wdata;
                    t_rdata = rd(t_addr);
                end
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_cs, mem_we, mem_oe}, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_ls_rdata"}, ls_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_din"},  mem_din,  0);
    endtask

    initial begin
        int n;
        int cs_cnt;
        bit seen;

        // Both requesters held from reset: grants must alternate LS, IF, LS, IF.
        if_req = 1; ls_req = 1; ls_we = 0;
        if_addr = 32'h100; ls_addr = 32'h200;
        repeat (3) tick;
        chk_all_zero("reset");
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(if_gnt || ls_gnt) && n < 20) begin
                tick;
                n++;
            end
            chk("contention_grant_seen", n < 20, 1);
            chk("contention_owner_ls", ls_gnt, k % 2 == 0);
            chk("contention_owner_if", if_gnt, k % 2 == 1);
            tick;
        end
        if_req = 0; ls_req = 0;
        repeat (12) tick;

        // LS write 0x24 <= 0x12345678: two-cycle access, no rvalid.
        ls_req = 1; ls_we = 1; ls_addr = 32'h24; ls_wdata = 32'h1234_5678;
        tick;
        chk("wr_gnt", ls_gnt, 1);
        chk("wr_pins", {mem_cs, mem_we, mem_oe}, 3'b110);
        chk("wr_din", mem_din, 32'h1234_5678);
        chk("wr_addr", mem_addr, 32'h24);
        ls_req = 0;
        tick;
        chk("wr_back_idle", mem_cs, 0);
        seen = 0;
        repeat (4) begin
            seen |= ls_rvalid;
            tick;
        end
        chk("wr_no_rvalid", seen, 0);

        // LS read of 0x24 with RD_LAT=3, IF request withdrawn during WAIT.
        ls_req = 1; ls_we = 0;
        tick;
        chk("rd_gnt", ls_gnt, 1);
        ls_req = 0;
        cs_cnt = 0;
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            cs_cnt += int'(mem_cs && mem_oe);
            seen |= if_gnt;
            if (i == 2) begin
                if_req = 1; if_addr = 32'h40;
            end
            if (i == 3) if_req = 0;
            if (i == 5) begin
                chk("rd_rvalid_t5", ls_rvalid, 1);
                chk("rd_rdata_t5", ls_rdata, 32'h1234_5678);
            end
            if (i == 6) begin
                chk("rd_rvalid_drop", ls_rvalid, 0);
                chk("rd_rdata_held", ls_rdata, 32'h1234_5678);
            end
            if (i >= 6) chk("rd_idle_after_done", mem_cs, 0);
            if (i < 8) tick;
        end
        chk("rd_cs_cycles", cs_cnt, 4);
        chk("withdrawn_no_if_gnt", seen, 0);

        // Randomised traffic over a small address window so reads hit writes.
        repeat (3000) begin
            tick;
            if_req   = ($urandom % 3) != 0;
            ls_req   = ($urandom % 2) != 0;
            ls_we    = ($urandom % 2) != 0;
            if_addr  = 32'($urandom_range(0, 15)) << 2;
            ls_addr  = 32'($urandom_range(0, 15)) << 2;
            ls_wdata = $urandom;
        end
        if_req = 0; ls_req = 0;
        repeat (12) tick;

        // Reset in the middle of an LS read's WAIT phase.
        ls_req = 1; ls_we = 0; ls_addr = 32'h8;
        tick;
        chk("abort_gnt", ls_gnt, 1);
        ls_req = 0;
        tick;
        chk("abort_in_wait", {mem_cs, mem_oe}, 2'b11);
        #1 rst_n = 0;
        #1 chk_all_zero("abort");
        repeat (2) tick;
        rst_n = 1;
        seen = 0;
        repeat (10) begin
            tick;
            seen |= ls_rvalid || (ls_rdata != 0);
        end
        chk("abort_no_rvalid", seen, 0);

        // RD_LAT=1 instance: IF read of 0x10 returning 0xDEADBEEF.
        if_req_1 = 1; if_addr_1 = 32'h10; mem_dout_1 = 32'h0;
        tick;
        chk("lat1_gnt", if_gnt_1, 1);
        chk("lat1_pins", {mem_cs_1, mem_we_1, mem_oe_1}, 3'b101);
        chk("lat1_addr", mem_addr_1, 32'h10);
        if_req_1 = 0;
        tick;
        chk("lat1_wait", {mem_cs_1, mem_oe_1, if_rvalid_1}, 3'b110);
        mem_dout_1 = 32'hDEAD_BEEF;
        tick;
        mem_dout_1 = 32'h0;
        chk("lat1_rvalid", if_rvalid_1, 1);
        chk("lat1_rdata", if_rdata_1, 32'hDEAD_BEEF);
        chk("lat1_cs_off", mem_cs_1, 0);
        tick;
        chk("lat1_rvalid_drop", if_rvalid_1, 0);
        chk("lat1_rdata_held", if_rdata_1, 32'hDEAD_BEEF);
        chk("lat1_ls_quiet", {ls_gnt_1, ls_rvalid_1, mem_we_1}, 0);
        chk("lat1_ls_rdata", ls_rdata_1, 0);
        chk("lat1_din", mem_din_1, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
`default_nettype wire
